// File: rtl/pipeline_pkg.sv
// pipeline_pkg: hazard FSM state encodings, default register-address width and stage control words.
package pipeline_pkg;

    localparam int REG_ADDR_W_DEF = 5;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } hz_state_e;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic id_ex_bubble;
        logic if_id_flush;
        logic id_ex_flush;
        logic ex_mem_flush;
    } hz_ctrl_t;

    localparam hz_ctrl_t CTRL_RUN   = hz_ctrl_t'(6'b110000);
    localparam hz_ctrl_t CTRL_STALL = hz_ctrl_t'(6'b001000);
    localparam hz_ctrl_t CTRL_FLUSH = hz_ctrl_t'(6'b110111);
    // Reset holds the front end and pushes NOPs into every downstream stage.
    localparam hz_ctrl_t CTRL_NOP   = hz_ctrl_t'(6'b001111);

endpackage

// File: rtl/hazard_cmp.sv
// hazard_cmp: load-use dependency compare between the load in EX and the source operands in ID.
module hazard_cmp
    import pipeline_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic [REG_ADDR_W-1:0] rt,
    input  logic                  uses_rs,
    input  logic                  uses_rt,
    input  logic                  mem_read,
    input  logic [REG_ADDR_W-1:0] rd,
    output logic                  lu_hazard
);

    assign lu_hazard = mem_read && (rd != '0) &&
                       ((uses_rs && (rd == rs)) || (uses_rt && (rd == rt)));

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use stall and taken-branch flush control; HAZARD_PERF_CNT_EN adds stall/flush counters.
module hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int REG_ADDR_W            = REG_ADDR_W_DEF,
    parameter int LOAD_USE_STALL_CYCLES = 1,
    parameter int CNT_W                 = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] if_id_rs,
    input  logic [REG_ADDR_W-1:0] if_id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic                  mem_read_out_id_ex,
    input  logic [REG_ADDR_W-1:0] rd_out_id_ex,
    input  logic                  branch_ex_mem,
    input  logic                  zero_ex_mem,
    output logic                  pc_write,
    output logic                  if_id_write,
    output logic                  id_ex_bubble,
    output logic                  if_id_flush,
    output logic                  id_ex_flush,
    output logic                  ex_mem_flush,
    output logic [1:0]            hazard_state
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
`endif
);

    localparam logic [2:0] REMAIN_INIT = 3'(LOAD_USE_STALL_CYCLES - 2);

    if (LOAD_USE_STALL_CYCLES < 1 || LOAD_USE_STALL_CYCLES > 7) begin : g_bad_cycles
        $error("LOAD_USE_STALL_CYCLES must be 1..7");
    end

    hz_state_e state_q, state_d;
    logic [2:0] remain_q, remain_d;
    hz_ctrl_t  ctrl;
    logic      lu_hazard;
    logic      take;

    hazard_cmp #(.REG_ADDR_W(REG_ADDR_W)) u_cmp (
        .rs        (if_id_rs),
        .rt        (if_id_rt),
        .uses_rs   (id_uses_rs),
        .uses_rt   (id_uses_rt),
        .mem_read  (mem_read_out_id_ex),
        .rd        (rd_out_id_ex),
        .lu_hazard (lu_hazard)
    );

    always_comb begin
        take     = branch_ex_mem & zero_ex_mem;
        ctrl     = CTRL_RUN;
        state_d  = ST_RUN;
        remain_d = '0;
        if (reset) begin
            ctrl = CTRL_NOP;
        end else if (take) begin
            ctrl    = CTRL_FLUSH;
            state_d = ST_FLUSH;
        end else if (state_q == ST_STALL) begin
            ctrl     = CTRL_STALL;
            state_d  = (remain_q == 3'd0) ? ST_RUN : ST_STALL;
            remain_d = (remain_q == 3'd0) ? 3'd0 : remain_q - 3'd1;
        end else if (lu_hazard) begin
            ctrl     = CTRL_STALL;
            state_d  = (LOAD_USE_STALL_CYCLES == 1) ? ST_RUN : ST_STALL;
            remain_d = (LOAD_USE_STALL_CYCLES == 1) ? 3'd0 : REMAIN_INIT;
        end
    end

    always_ff @(posedge clk) begin
        state_q  <= state_d;
        remain_q <= remain_d;
    end

    assign {pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush, ex_mem_flush} = ctrl;
    assign hazard_state = reset ? ST_RUN : state_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = reset ? '0 : stall_cnt_q + CNT_W'(ctrl.id_ex_bubble);
        flush_cnt_d = reset ? '0 : flush_cnt_q + CNT_W'(take);
    end

    always_ff @(posedge clk) begin
        stall_cnt_q <= stall_cnt_d;
        flush_cnt_q <= flush_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: two hazard_ctrl instances (1 and 3 stall cycles) checked against a cycle-level model.
module tb_hazard_ctrl;

    localparam int W = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic [W-1:0] rs, rt, rd;
    logic         urs, urt, mr, br, zr;
    logic [1:0]   pw, iw, bub, f1, f2, f3;
    logic [1:0]   st0, st1;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0]  sc0, fc0;
    logic [3:0]   sc1, fc1;
`endif

    int errors = 0;
    int checks = 0;

    hazard_ctrl #(.REG_ADDR_W(W), .LOAD_USE_STALL_CYCLES(1), .CNT_W(32)) dut1 (
        .clk(clk), .reset(reset), .if_id_rs(rs), .if_id_rt(rt),
        .id_uses_rs(urs), .id_uses_rt(urt), .mem_read_out_id_ex(mr), .rd_out_id_ex(rd),
        .branch_ex_mem(br), .zero_ex_mem(zr),
        .pc_write(pw[0]), .if_id_write(iw[0]), .id_ex_bubble(bub[0]),
        .if_id_flush(f1[0]), .id_ex_flush(f2[0]), .ex_mem_flush(f3[0]),
        .hazard_state(st0)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cnt(sc0), .flush_cnt(fc0)
`endif
    );

    hazard_ctrl #(.REG_ADDR_W(W), .LOAD_USE_STALL_CYCLES(3), .CNT_W(4)) dut3 (
        .clk(clk), .reset(reset), .if_id_rs(rs), .if_id_rt(rt),
        .id_uses_rs(urs), .id_uses_rt(urt), .mem_read_out_id_ex(mr), .rd_out_id_ex(rd),
        .branch_ex_mem(br), .zero_ex_mem(zr),
        .pc_write(pw[1]), .if_id_write(iw[1]), .id_ex_bubble(bub[1]),
        .if_id_flush(f1[1]), .id_ex_flush(f2[1]), .ex_mem_flush(f3[1]),
        .hazard_state(st1)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cnt(sc1), .flush_cnt(fc1)
`endif
    );

    function automatic void chk(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    // Model: bubbles still owed after this cycle, whether last cycle took a branch, event counts.
    int     left  [2] = '{0, 0};
    bit     ptake [2] = '{0, 0};
    longint scnt  [2] = '{0, 0};
    longint fcnt  [2] = '{0, 0};
    int     ncyc  [2] = '{1, 3};
    longint cmask [2] = '{64'hFFFF_FFFF, 64'hF};

    function automatic bit lu();
        return mr && rd != 0 && ((urs && rd == rs) || (urt && rd == rt));
    endfunction

    function automatic bit stalled(int i);
        return !(br && zr) && (left[i] > 0 || lu());
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                left[i]  <= 0;
                ptake[i] <= 0;
                scnt[i]  <= 0;
                fcnt[i]  <= 0;
            end else begin
                ptake[i] <= br && zr;
                if (br && zr) left[i] <= 0;
                else if (left[i] > 0) left[i] <= left[i] - 1;
                else if (lu()) left[i] <= ncyc[i] - 1;
                scnt[i] <= scnt[i] + longint'(stalled(i));
                fcnt[i] <= fcnt[i] + longint'(br && zr);
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic [7:0] e;
            logic [7:0] a;
            logic [1:0] es;
            es = reset ? 2'd0 : ptake[i] ? 2'd2 : (left[i] > 0) ? 2'd1 : 2'd0;
            if (reset) e = {6'b001111, es};
            else if (br && zr) e = {6'b110111, es};
            else if (stalled(i)) e = {6'b001000, es};
            else e = {6'b110000, es};
            a = {pw[i], iw[i], bub[i], f1[i], f2[i], f3[i], (i == 0) ? st0 : st1};
            chk($sformatf("model_outputs_n%0d", ncyc[i]), a, e);
`ifdef HAZARD_PERF_CNT_EN
            chk($sformatf("model_stall_cnt_n%0d", ncyc[i]), (i == 0) ? sc0 : sc1, scnt[i] & cmask[i]);
            chk($sformatf("model_flush_cnt_n%0d", ncyc[i]), (i == 0) ? fc0 : fc1, fcnt[i] & cmask[i]);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        mr = 0; br = 0; zr = 0; urs = 0; urt = 0; rs = 0; rt = 0; rd = 0;
    endtask

    task automatic set_lu();
        mr = 1; rd = 5; rs = 5; urs = 1; urt = 0; rt = 0;
    endtask

    initial begin
        reset = 1;
        idle();
        #1;
        chk("reset_pc_write", pw[0], 0);
        chk("reset_if_id_flush", f1[0], 1);
        tick();
        chk("reset2_ex_mem_flush", f3[1], 1);
        tick();
        reset = 0;
        #2;
        chk("post_reset_state", st0, 0);
        chk("post_reset_pc_write", pw[0], 1);
        chk("post_reset_no_flush", f2[1], 0);
        tick();
        set_lu();
        #2;
        chk("lu_pc_write_n1", pw[0], 0);
        chk("lu_bubble_n1", bub[0], 1);
        chk("lu_state_n3_c0", st1, 0);
        tick();
        idle();
        #2;
        chk("lu_after_pc_write_n1", pw[0], 1);
        chk("lu_state_n3_c1", st1, 1);
        chk("lu_bubble_n3_c1", bub[1], 1);
        tick();
        chk("lu_state_n3_c2", st1, 1);
        chk("lu_bubble_n3_c2", bub[1], 1);
        tick();
        chk("lu_state_n3_c3", st1, 0);
        chk("lu_pc_write_n3_c3", pw[1], 1);
        mr = 1; rd = 0; rs = 0; urs = 1;
        #2;
        chk("rd0_no_stall", pw[1], 1);
        tick();
        mr = 1; rd = 7; rt = 7; urt = 0; urs = 0;
        #2;
        chk("unused_rt_no_stall", pw[1], 1);
        tick();
        set_lu();
        tick();
        idle();
        br = 1; zr = 1;
        #2;
        chk("take_in_stall_pc_write", pw[1], 1);
        chk("take_in_stall_flushes", {f1[1], f2[1], f3[1]}, 3'b111);
        chk("take_in_stall_no_bubble", bub[1], 0);
        tick();
        br = 0; zr = 0;
        #2;
        chk("after_take_state", st1, 2);
        chk("after_take_no_flush", f1[1], 0);
        tick();
        chk("after_flush_state", st1, 0);
        reset = 1;
        tick();
        reset = 0;
        set_lu();
        repeat (17) tick();
        idle();
        #2;
`ifdef HAZARD_PERF_CNT_EN
        chk("stall_cnt_wrap", sc1, 1);
`endif
        set_lu();
        tick();
        idle();
        reset = 1;
        tick();
        reset = 0;
        #2;
        chk("reset_mid_stall_state", st1, 0);
        chk("reset_mid_stall_pc_write", pw[1], 1);
`ifdef HAZARD_PERF_CNT_EN
        chk("reset_mid_stall_cnt", sc1, 0);
`endif
        repeat (3000) begin
            tick();
            reset = ($urandom_range(0, 49) == 0);
            mr    = $urandom_range(0, 1) == 1;
            rd    = W'($urandom_range(0, 3));
            rs    = W'($urandom_range(0, 3));
            rt    = W'($urandom_range(0, 3));
            urs   = $urandom_range(0, 1) == 1;
            urt   = $urandom_range(0, 1) == 1;
            br    = $urandom_range(0, 3) == 0;
            zr    = $urandom_range(0, 1) == 1;
        end
        tick();
        idle();
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
